// File: rtl/mio_bus_responder.sv
// mio_bus_responder: CPU memory/IO bus responder with word RAM, switches, LED register and cycle counter.
// A request is latched in IDLE, held for WAIT_CYCLES wait states, performed once, then acknowledged for one cycle.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int SW_W        = 16,
  parameter int LED_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CPU_MIO,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             MIO_ready,
  input  logic [SW_W-1:0]  SW,
  output logic [LED_W-1:0] LED,
  output logic             bus_err,
  output logic [1:0]       state
);

  // state | meaning
  // IDLE  | waiting for CPU_MIO; request registers loaded on accept
  // WAIT  | wait-state down-counter running; access performed at terminal count
  // ACK   | MIO_ready high for this single cycle, then back to IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         RAM_WORDS = 1 << RAM_AW;

  logic [1:0]        state_q;
  logic [3:0]        wait_cnt;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_w;

  logic [SW_W-1:0]   sw_q;
  logic [LED_W-1:0]  led_q;
  logic [31:0]       ctr_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       ram [RAM_WORDS];

  logic              access;
  logic              wr_acc;
  logic              rd_acc;
  logic              sel_ram;
  logic              sel_sw;
  logic              sel_led;
  logic              sel_ctr;
  logic              sel_none;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_val;

  // Upper RAM-region bits alias and the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[27:RAM_AW+2], req_addr[1:0]};

  assign ram_idx = req_addr[RAM_AW+1:2];
  assign access  = (state_q == ST_WAIT) && (wait_cnt == 4'd0);
  assign wr_acc  = access && req_w;
  assign rd_acc  = access && !req_w;

  always_comb begin
    sel_ram  = 1'b0;
    sel_sw   = 1'b0;
    sel_led  = 1'b0;
    sel_ctr  = 1'b0;
    sel_none = 1'b0;
    case (req_addr[31:28])
      4'h0:    sel_ram  = 1'b1;
      4'hE:    sel_sw   = 1'b1;
      4'hF: begin
        sel_led = !req_addr[2];
        sel_ctr = req_addr[2];
      end
      default: sel_none = 1'b1;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (sel_ram)
      rd_val = ram[ram_idx];
    else if (sel_sw)
      rd_val[SW_W-1:0] = sw_q;
    else if (sel_led)
      rd_val[LED_W-1:0] = led_q;
    else if (sel_ctr)
      rd_val = ctr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wait_cnt  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_w     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CPU_MIO) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_w     <= mem_w;
            wait_cnt  <= WAIT_INIT;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
          else
            state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A counter write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_q    <= '0;
      led_q   <= '0;
      ctr_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sw_q <= SW;
      if (wr_acc && sel_ctr)
        ctr_q <= req_wdata;
      else
        ctr_q <= ctr_q + 32'd1;
      if (wr_acc && sel_led)
        led_q <= req_wdata[LED_W-1:0];
      if (rd_acc)
        rdata_q <= rd_val;
      if (access && sel_none)
        err_q <= 1'b1;
    end
  end

  // RAM is not reset, but a write landing on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (reset && wr_acc && sel_ram)
      ram[ram_idx] <= req_wdata;
  end

  assign rdata     = rdata_q;
  assign MIO_ready = (state_q == ST_ACK);
  assign LED       = led_q;
  assign bus_err   = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: one WAIT_CYCLES=1 instance for directed accesses,
// one WAIT_CYCLES=0 instance for a back-to-back request stream with CPU_MIO held high.
module tb_mio_bus_responder;
  typedef struct { bit rd; logic [31:0] exp; } sb_entry_t;

  localparam int WAIT1 = 1;
  localparam int NOPS  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        cpu_mio = 1'b0;
  logic        mem_w   = 1'b0;
  logic [31:0] addr    = '0;
  logic [31:0] wdata   = '0;
  logic [31:0] rdata;
  logic        mio_ready;
  logic [15:0] sw      = '0;
  logic [15:0] led;
  logic        bus_err;
  logic [1:0]  state;

  logic        c0_mio   = 1'b0;
  logic        c0_w     = 1'b0;
  logic [31:0] c0_addr  = '0;
  logic [31:0] c0_wdata = '0;
  logic [31:0] c0_rdata;
  logic        c0_ready;
  logic [15:0] c0_sw    = 16'h1234;
  logic [15:0] c0_led;
  logic        c0_err;
  logic [1:0]  c0_state;

  int n_chk = 0;
  int n_pass = 0;
  int unsigned cyc = 0;
  sb_entry_t sb_q[$];
  sb_entry_t sb0_q[$];
  sb_entry_t e1, e0;
  logic [31:0] wd [NOPS/2];

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(WAIT1), .SW_W(16), .LED_W(16)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(cpu_mio), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .MIO_ready(mio_ready), .SW(sw), .LED(led), .bus_err(bus_err), .state(state)
  );

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0), .SW_W(16), .LED_W(16)) dut0 (
    .clk(clk), .reset(reset), .CPU_MIO(c0_mio), .mem_w(c0_w), .addr(c0_addr), .wdata(c0_wdata),
    .rdata(c0_rdata), .MIO_ready(c0_ready), .SW(c0_sw), .LED(c0_led), .bus_err(c0_err), .state(c0_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mio_ready === 1'b1) begin
      if (sb_q.size() == 0) chk("sb1_spurious_ready", 32'd1, 32'd0);
      else begin
        e1 = sb_q.pop_front();
        if (e1.rd) chk("sb1_rdata", rdata, e1.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (c0_ready === 1'b1) begin
      if (sb0_q.size() == 0) chk("sb0_spurious_ready", 32'd1, 32'd0);
      else begin
        e0 = sb0_q.pop_front();
        if (e0.rd) chk("sb0_rdata", c0_rdata, e0.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT idle; returns at the same phase.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string tag);
    logic [9:0] seq;
    int n;
    bit got;
    sb_q.push_back('{rd: !w, exp: exp});
    seq = {8'd0, state};
    cpu_mio = 1'b1; mem_w = w; addr = a; wdata = d;
    @(posedge clk); #1;
    cpu_mio = 1'b0; mem_w = ~w; addr = 32'hD000_0004; wdata = ~d;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      seq = {seq[7:0], state};
      if (mio_ready === 1'b1) got = 1;
      else n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WAIT1 + 1));
    @(posedge clk); #1;
    seq = {seq[7:0], state};
    chk({tag, "_pulse_width"}, 32'(mio_ready), 32'd0);
    chk({tag, "_state_seq"}, 32'(seq), 32'(10'b00_01_01_10_00));
  endtask

  task automatic drive0(input int i);
    c0_w    = (i % 2 == 0);
    c0_addr = 32'h0000_0100 + 32'(4 * (i / 2));
    if (c0_w) begin
      c0_wdata = wd[i/2];
      sb0_q.push_back('{rd: 1'b0, exp: 32'd0});
    end else begin
      c0_wdata = $urandom;
      sb0_q.push_back('{rd: 1'b1, exp: wd[i/2]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ld_edge;
    int unsigned rst_edge;
    int pulses;
    int n;
    int last_pulse;
    logic [31:0] exp_v;

    reset = 1'b0;
    tick(3);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(mio_ready), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    reset = 1'b1;
    tick(1);

    xact(1'b1, 32'h0000_0010, 32'h1234_5678, 32'd0, "ram_wr");
    xact(1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, "ram_rd");
    xact(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'd0, "ram_wr2");
    chk("rdata_hold_on_write", rdata, 32'h1234_5678);
    xact(1'b0, 32'h0000_1010, 32'd0, 32'h1234_5678, "ram_alias_rd");
    xact(1'b0, 32'h0000_0014, 32'd0, 32'hCAFE_F00D, "ram_rd2");

    xact(1'b1, 32'hF000_0000, 32'h0000_A5A5, 32'd0, "led_wr");
    chk("led_value", 32'(led), 32'h0000_A5A5);
    xact(1'b0, 32'hF000_0000, 32'd0, 32'h0000_A5A5, "led_rd");

    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'hF000_0000; wdata = 32'h0000_1111;
    tick(1);
    chk("rst_mid_pre_state", 32'(state), 32'd1);
    reset = 1'b0; cpu_mio = 1'b0;
    tick(2);
    rst_edge = cyc;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mio_ready === 1'b1) pulses++;
    end
    @(posedge clk); #1;
    chk("rst_mid_no_ready", 32'(pulses), 32'd0);
    chk("rst_mid_led", 32'(led), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    exp_v = 32'(cyc + 3 - 1 - rst_edge);
    xact(1'b0, 32'hF000_0004, 32'd0, exp_v, "ctr_after_rst");

    sw = 16'hBEEF;
    tick(2);
    xact(1'b0, 32'hE000_0000, 32'd0, 32'h0000_BEEF, "sw_rd");
    xact(1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 32'd0, "sw_wr");
    chk("sw_wr_rdata", rdata, 32'h0000_BEEF);
    chk("sw_wr_bus_err", 32'(bus_err), 32'd0);
    chk("sw_wr_led", 32'(led), 32'd0);

    ld_edge = cyc + 3;
    xact(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'd0, "ctr_wr");
    exp_v = 32'hFFFF_FFFE + 32'(cyc + 3 - 1 - ld_edge);
    xact(1'b0, 32'hF000_0004, 32'd0, exp_v, "ctr_wrap_rd");
    tick(5);
    exp_v = 32'hFFFF_FFFE + 32'(cyc + 3 - 1 - ld_edge);
    xact(1'b0, 32'hF000_0004, 32'd0, exp_v, "ctr_rd2");

    chk("err_before", 32'(bus_err), 32'd0);
    xact(1'b0, 32'h4000_0000, 32'd0, 32'd0, "unmapped_rd");
    chk("err_set", 32'(bus_err), 32'd1);
    xact(1'b1, 32'h5000_0010, 32'h0BAD_0BAD, 32'd0, "unmapped_wr");
    xact(1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, "ram_after_unmapped");
    chk("err_sticky", 32'(bus_err), 32'd1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("err_cleared", 32'(bus_err), 32'd0);

    for (int i = 0; i < NOPS / 2; i++) wd[i] = $urandom;
    drive0(0);
    c0_mio = 1'b1;
    pulses = 0; n = 0; last_pulse = -1;
    while (pulses < NOPS && n < 200) begin
      @(negedge clk);
      n++;
      if (c0_ready === 1'b1) begin
        if (last_pulse >= 0) chk("b2b_interval", 32'(n - last_pulse), 32'd3);
        last_pulse = n;
        pulses++;
        if (pulses < NOPS) drive0(pulses);
        else c0_mio = 1'b0;
      end
    end
    tick(6);
    chk("b2b_pulses", 32'(pulses), 32'(NOPS));
    chk("b2b_queue_empty", 32'(sb0_q.size()), 32'd0);
    chk("sb1_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Bus responder for the multicycle CPU's memory/IO request interface: accepts CPU_MIO / mem_w / address / write-data requests and returns read data with an MIO_ready handshake.
- Decodes each request to word RAM, switch input, LED register or a free-running cycle counter, and inserts a programmable number of wait states.
- Sits between the CPU core and board-level memory/peripherals.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM is 2^RAM_AW x 32 bits.
- WAIT_CYCLES, 1, extra wait states per access, range 0..15.
- SW_W, 16, switch input width.
- LED_W, 16, LED register width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- CPU_MIO  input  1  request valid from the CPU; held until MIO_ready.
- mem_w  input  1  1 = write, 0 = read; qualified by CPU_MIO.
- addr  input  32  byte address from the CPU; bits [1:0] ignored.
- wdata  input  32  write data from the CPU.
- rdata  output  32  read data to the CPU (CPU Data_in).
- MIO_ready  output  1  one-cycle completion strobe.
- SW  input  SW_W  board switches.
- LED  output  LED_W  LED register.
- bus_err  output  1  sticky unmapped-access flag.
- state  output  2  FSM state: IDLE=0, WAIT=1, ACK=2.

Behaviour:
- Reset (reset==0 at an edge, including mid-transaction):
  - state=IDLE; MIO_ready=0; rdata=0; LED=0; bus_err=0; counter=0; sw_q=0.
  - RAM contents are not reset.
  - An in-flight write is discarded. The CPU restarts its own transaction.
- sw_q <= SW every cycle. Switch reads return sw_q, zero-extended to 32 bits.
- Counter: +1 every cycle, wraps 0xFFFFFFFF -> 0. A write to the counter loads wdata and replaces that cycle's increment.
- Address decode, using addr[31:28]:
  - 0x0: RAM word addr[RAM_AW+1:2]; higher address bits are ignored, so the RAM aliases.
  - 0xE: switches, read-only. Writes are ignored and do not set bus_err.
  - 0xF, addr[2]=0: LED register, R/W. Reads are zero-extended; writes take wdata[LED_W-1:0].
  - 0xF, addr[2]=1: counter, R/W.
  - Any other region: unmapped. Reads return 0x00000000, writes are dropped, and bus_err is set to 1 until reset.
- FSM:
  - IDLE: if CPU_MIO==1, latch addr/wdata/mem_w into request registers, load cnt=WAIT_CYCLES, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt!=0, cnt-- and stay. If cnt==0, perform the access from the latched request at this edge (write commit, or capture the read into rdata), then go to ACK.
  - ACK: MIO_ready=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: if CPU_MIO is sampled at edge k, MIO_ready is high in the cycle following edge k+1+WAIT_CYCLES. Examples: WAIT_CYCLES=0 -> 2 cycles; 1 -> 3 cycles.
- Back-to-back requests: CPU_MIO still high in the cycle after ACK is treated as a new request, accepted in IDLE. At least one IDLE cycle always separates two MIO_ready pulses.
- Request inputs are sampled only in IDLE. Changes to addr/wdata/mem_w during WAIT/ACK have no effect.
- rdata:
  - Updated only on a read access edge; holds its value through later writes and idle cycles.
  - A write access leaves rdata unchanged.
  - A counter read returns the counter value before that edge's increment.
- A CPU_MIO drop during WAIT does not abort the transaction: the access completes and MIO_ready still pulses.

Test Plan:
- Reset, then WAIT_CYCLES=1: write 0x12345678 to 0x00000010, then read 0x00000010 -> rdata=0x12345678. MIO_ready is high 3 cycles after each request sample and for exactly 1 cycle; state sequence 0,1,1,2,0.
- Write 0x0000A5A5 to 0xF0000000 -> LED=0xA5A5 after the access edge. Read back -> 0x0000A5A5. Assert reset mid-WAIT of a second LED write 0x1111 -> LED=0, MIO_ready never pulses, state=0.
- SW=0xBEEF held for 2 cycles, read 0xE0000000 -> 0x0000BEEF. Write 0xFFFFFFFF to 0xE0000000 -> no state change, bus_err stays 0.
- Write 0xFFFFFFFE to 0xF0000004, then read the counter -> wraps through 0x00000000. The returned value equals the load value plus the elapsed cycles, mod 2^32.
- Read 0x40000000 -> rdata=0, bus_err=1. bus_err stays 1 after later valid accesses until reset.
- WAIT_CYCLES=0 build, CPU_MIO held high continuously with alternating RAM writes/reads -> MIO_ready pulses every 3rd cycle, every read returns the last written data, and no request is lost or duplicated.
